regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
Writeback initiator for the integer register file. It drives the register file's single write port (enable, destination index, data) from two result sources: the single-cycle ALU path and a multi-cycle load path. A small FIFO buffers load results while the ALU holds the port. A pending-load scoreboard lets issue logic detect RAW hazards on outstanding loads.

Parameters:
DEPTH, 4, load-result queue entries (power of two, >=2)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
alu_valid_i  input  1  ALU result valid this cycle (always accepted)
alu_rd_i  input  5  ALU destination index
alu_data_i  input  32  ALU result
alu_stall_o  output  1  queue full; upstream must hold further ALU results
ld_valid_i  input  1  load result valid
ld_ready_o  output  1  load queue can accept
ld_rd_i  input  5  load destination index
ld_data_i  input  32  load data
issue_load_i  input  1  a load is issued this cycle
issue_rd_i  input  5  destination of the issued load
chk_rs1_i  input  5  source index 1 to check
chk_rs2_i  input  5  source index 2 to check
hazard_o  output  1  chk_rs1_i or chk_rs2_i has a pending load
wr_en_o  output  1  register-file write enable
rd_idx_o  output  5  register-file write index
rd_data_o  output  32  register-file write data

Behaviour:
- Reset (rst_i high, async): wr_en_o=0, rd_idx_o=0, rd_data_o=0; queue emptied (count=0); pending bitmap cleared. ld_ready_o=0 and alu_stall_o=0 while rst_i is high. Reset mid-operation discards all queued loads and pending bits; no write is emitted.
- Write-port arbitration, evaluated each rising edge:
  - If alu_valid_i=1: the write-port output register loads the ALU result.
  - Else, if the queue is non-empty: the queue head is popped into the output register.
  - Else: wr_en_o<=0.
  - ALU has strict priority.
- All write-port outputs are registered. ALU latency is 1 cycle: valid at edge N gives wr_en_o high in cycle N+1.
- Load latency into an empty queue with no ALU traffic is 2 cycles: accepted at edge N, popped at edge N+1, wr_en_o high in cycle N+2. There is no push-to-output bypass.
- x0 writes: a selected entry with rd=0 sets wr_en_o<=0. rd_idx_o and rd_data_o still update, and the entry is still consumed/popped.
- Queue:
  - Push when ld_valid_i && ld_ready_o.
  - ld_ready_o = (count<DEPTH), combinational from registered count.
  - Push and pop in the same cycle leave count unchanged.
  - When full, ld_ready_o=0, so a simultaneous pop does not admit a push that cycle.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
- alu_stall_o = (count==DEPTH), combinational. It is advisory only: an ALU result presented anyway is still written, and the queue simply does not drain that cycle.
- Scoreboard (32-bit pend, bit 0 forced 0):
  - Set: pend[issue_rd_i]<=1 on issue_load_i with issue_rd_i!=0.
  - Clear: pend[idx]<=0 at the edge a load entry with that idx is popped.
  - Set and clear of the same index in the same cycle: set wins.
  - ALU writes never modify pend.
- hazard_o = (chk_rs1_i!=0 && pend[chk_rs1_i]) || (chk_rs2_i!=0 && pend[chk_rs2_i]), combinational. It reflects registered pend only; a same-cycle set is not visible until the next cycle.

Test Plan:
1. ALU only: alu_valid_i=1, rd=5, data=0x12345678 at edge 0 -> cycle 1: wr_en_o=1, rd_idx_o=5, rd_data_o=0x12345678; cycle 2 (no input): wr_en_o=0.
2. Load path: issue_load_i with rd=7 -> next cycle hazard_o=1 for chk_rs1_i=7. Then ld_valid_i rd=7, data=0xCAFEF00D accepted at edge N -> cycle N+2: wr_en_o=1 with rd 7 and that data; hazard_o=0 from cycle N+2.
3. Contention: ALU valid for 6 consecutive cycles while 5 loads are offered (DEPTH=4):
   - After 4 loads, ld_ready_o=0 and alu_stall_o=1; the 5th load is held.
   - When the ALU drops, loads drain in order, one per cycle, data matching the push order.
   - Total writes = 11; no loss or duplication.
4. x0: ALU write rd=0 -> wr_en_o stays 0. A queued load to rd=0 is popped (count decrements) with wr_en_o=0, and pend is unchanged.
5. Scoreboard race: a load to rd=3 pops in the same cycle as issue_load_i rd=3 -> pend[3]=1 afterward, hazard_o=1 for chk_rs2_i=3.
6. Reset mid-operation: with 3 entries queued and pend[9]=1, pulse rst_i asynchronously between edges:
   - Outputs go to 0 immediately; no writes occur after release.
   - ld_ready_o=1 after release; hazard_o=0 for index 9.

Source files
------------

// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb
// Purpose  : Writeback initiator for the integer register file. Drives the
//            single register-file write port from two result sources:
//              - the single-cycle ALU path (strict priority), and
//              - the multi-cycle load path, buffered in a small FIFO so that
//                load results are not lost while the ALU holds the port.
//            A pending-load scoreboard flags RAW hazards on loads that have
//            been issued but not yet written back.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        load-result queue entries (power of two, >= 2)
// Ports
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   alu_valid_i  ALU result valid this cycle (always accepted)
//   alu_rd_i     ALU destination index
//   alu_data_i   ALU result
//   alu_stall_o  queue full; upstream should hold further ALU results
//   ld_valid_i   load result valid
//   ld_ready_o   load queue can accept
//   ld_rd_i      load destination index
//   ld_data_i    load data
//   issue_load_i a load is issued this cycle
//   issue_rd_i   destination of the issued load
//   chk_rs1_i    source index 1 to check
//   chk_rs2_i    source index 2 to check
//   hazard_o     chk_rs1_i or chk_rs2_i has a pending load
//   wr_en_o      register-file write enable
//   rd_idx_o     register-file write index
//   rd_data_o    register-file write data
// ============================================================================
module regfile_wb #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_stall_o,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_rd_i,
  input  logic [31:0] ld_data_i,
  input  logic        issue_load_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  chk_rs1_i,
  input  logic [4:0]  chk_rs2_i,
  output logic        hazard_o,
  output logic        wr_en_o,
  output logic [4:0]  rd_idx_o,
  output logic [31:0] rd_data_o
);

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own; the
  // occupancy counter needs one extra bit to represent "full".
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  // --------------------------------------------------------------------------
  // Load-result queue state
  // --------------------------------------------------------------------------
  logic [4:0]         r_q_rd   [DEPTH];
  logic [31:0]        r_q_data [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;

  // Pending-load scoreboard, one bit per architectural register.
  logic [31:0]        r_pend;
  logic [31:0]        w_pend_nxt;

  // Registered write port.
  logic               r_wr_en;
  logic [4:0]         r_rd_idx;
  logic [31:0]        r_rd_data;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [4:0]         w_head_rd;
  logic [31:0]        w_head_data;

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  // Both handshake outputs are held low while reset is asserted so that no
  // upstream unit sees the queue as available before it is usable.
  assign w_empty     = (r_count == '0);
  assign ld_ready_o  = !rst_i && (r_count < c_FULL);
  assign alu_stall_o = !rst_i && (r_count == c_FULL);

  // A push is only admitted against the registered count, so a pop in the
  // same cycle as a full queue does not open a slot until the next cycle.
  assign w_push = ld_valid_i && ld_ready_o;

  // The ALU owns the port whenever it presents a result; the queue only
  // drains in cycles the ALU leaves idle.
  assign w_pop  = !alu_valid_i && !w_empty;

  assign w_head_rd   = r_q_rd[r_rptr];
  assign w_head_data = r_q_data[r_rptr];

  // --------------------------------------------------------------------------
  // Queue storage: data path only, contents are qualified by r_count so no
  // reset is needed here.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= ld_rd_i;
      r_q_data[r_wptr] <= ld_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Queue pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard next state
  // --------------------------------------------------------------------------
  // The clear is applied before the set so that a load retiring to the same
  // register that a new load is being issued to leaves the bit set: the
  // younger load is still outstanding. Bit 0 never records a hazard since
  // x0 is hard-wired.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pop) begin
      w_pend_nxt[w_head_rd] = 1'b0;
    end
    if (issue_load_i) begin
      w_pend_nxt[issue_rd_i] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  // Hazard reflects only the registered scoreboard; an issue in this cycle
  // becomes visible in the next.
  assign hazard_o = ((chk_rs1_i != 5'd0) && r_pend[chk_rs1_i]) ||
                    ((chk_rs2_i != 5'd0) && r_pend[chk_rs2_i]);

  // --------------------------------------------------------------------------
  // Write-port output register
  // --------------------------------------------------------------------------
  // Writes to x0 are suppressed by deasserting the enable, but index and data
  // still follow the selected source and the entry is still consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_en   <= 1'b0;
      r_rd_idx  <= 5'd0;
      r_rd_data <= 32'd0;
    end else if (alu_valid_i) begin
      r_wr_en   <= (alu_rd_i != 5'd0);
      r_rd_idx  <= alu_rd_i;
      r_rd_data <= alu_data_i;
    end else if (w_pop) begin
      r_wr_en   <= (w_head_rd != 5'd0);
      r_rd_idx  <= w_head_rd;
      r_rd_data <= w_head_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign wr_en_o   = r_wr_en;
  assign rd_idx_o  = r_rd_idx;
  assign rd_data_o = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb
// Purpose  : Directed self-checking bench for regfile_wb (DEPTH = 4).
//            Inputs change 1 ns after a rising edge; outputs are sampled
//            there too, well away from the next active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb;

  logic        clk_i;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        alu_stall_o;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [4:0]  ld_rd_i;
  logic [31:0] ld_data_i;
  logic        issue_load_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  chk_rs1_i;
  logic [4:0]  chk_rs2_i;
  logic        hazard_o;
  logic        wr_en_o;
  logic [4:0]  rd_idx_o;
  logic [31:0] rd_data_o;

  int checks;
  int failures;

  regfile_wb #(.DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alu_valid_i  (alu_valid_i),
    .alu_rd_i     (alu_rd_i),
    .alu_data_i   (alu_data_i),
    .alu_stall_o  (alu_stall_o),
    .ld_valid_i   (ld_valid_i),
    .ld_ready_o   (ld_ready_o),
    .ld_rd_i      (ld_rd_i),
    .ld_data_i    (ld_data_i),
    .issue_load_i (issue_load_i),
    .issue_rd_i   (issue_rd_i),
    .chk_rs1_i    (chk_rs1_i),
    .chk_rs2_i    (chk_rs2_i),
    .hazard_o     (hazard_o),
    .wr_en_o      (wr_en_o),
    .rd_idx_o     (rd_idx_o),
    .rd_data_o    (rd_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i  = 1'b0;
    alu_rd_i     = 5'd0;
    alu_data_i   = 32'd0;
    ld_valid_i   = 1'b0;
    ld_rd_i      = 5'd0;
    ld_data_i    = 32'd0;
    issue_load_i = 1'b0;
    issue_rd_i   = 5'd0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    chk_rs1_i = 5'd0;
    chk_rs2_i = 5'd0;
    tick();
    tick();
    checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_o); end
    checks++; if (rd_idx_o !== 5'd0) begin failures++; $display("FAIL reset_rd_idx got=%0d exp=0", rd_idx_o); end
    checks++; if (rd_data_o !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data_o); end
    checks++; if (ld_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready_o); end
    checks++; if (alu_stall_o !== 1'b0) begin failures++; $display("FAIL reset_alu_stall got=%b exp=0", alu_stall_o); end
    rst_i = 1'b0;
    #1;
    checks++; if (ld_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ld_ready got=%b exp=1", ld_ready_o); end
    tick();
  endtask

  task automatic test_alu();
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h1234_5678;
    tick();
    idle_inputs();
    checks++; if (wr_en_o !== 1'b1) begin failures++; $display("FAIL alu_wr_en got=%b exp=1", wr_en_o); end
    checks++; if (rd_idx_o !== 5'd5) begin failures++; $display("FAIL alu_rd_idx got=%0d exp=5", rd_idx_o); end
    checks++; if (rd_data_o !== 32'h1234_5678) begin failures++; $display("FAIL alu_rd_data got=%h exp=12345678", rd_data_o); end
    tick();
    checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL alu_idle_wr_en got=%b exp=0", wr_en_o); end
  endtask

  task automatic test_load();
    issue_load_i = 1'b1; issue_rd_i = 5'd7; chk_rs1_i = 5'd7; chk_rs2_i = 5'd0;
    #1;
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL load_same_cycle_hazard got=%b exp=0", hazard_o); end
    tick();
    idle_inputs();
    #1;
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL load_pending_hazard got=%b exp=1", hazard_o); end
    ld_valid_i = 1'b1; ld_rd_i = 5'd7; ld_data_i = 32'hCAFE_F00D;
    #1;
    checks++; if (ld_ready_o !== 1'b1) begin failures++; $display("FAIL load_ready got=%b exp=1", ld_ready_o); end
    tick();                                   // edge N: push
    idle_inputs();
    checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL load_n1_wr_en got=%b exp=0", wr_en_o); end
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL load_n1_hazard got=%b exp=1", hazard_o); end
    tick();                                   // edge N+1: pop
    checks++; if (wr_en_o !== 1'b1) begin failures++; $display("FAIL load_n2_wr_en got=%b exp=1", wr_en_o); end
    checks++; if (rd_idx_o !== 5'd7) begin failures++; $display("FAIL load_n2_rd_idx got=%0d exp=7", rd_idx_o); end
    checks++; if (rd_data_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL load_n2_rd_data got=%h exp=cafef00d", rd_data_o); end
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL load_n2_hazard got=%b exp=0", hazard_o); end
    tick();
    checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL load_n3_wr_en got=%b exp=0", wr_en_o); end
    chk_rs1_i = 5'd0;
  endtask

  // Six ALU results back to back with five loads offered. The bench keeps
  // its own occupancy model to know which loads are admitted.
  task automatic test_contention();
    int mcount;
    int j;
    int writes;
    logic push;
    logic pop;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    mcount = 0; j = 0; writes = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid_i = (c < 6);
      alu_rd_i    = 5'(10 + c);
      alu_data_i  = 32'hA000_0000 + 32'(c);
      ld_valid_i  = (j < 5);
      ld_rd_i     = 5'(20 + j);
      ld_data_i   = 32'hB000_0000 + 32'(j);
      #1;
      checks++; if (ld_ready_o !== (mcount < 4)) begin failures++; $display("FAIL cont_ld_ready c=%0d got=%b exp=%b", c, ld_ready_o, (mcount < 4)); end
      checks++; if (alu_stall_o !== (mcount == 4)) begin failures++; $display("FAIL cont_alu_stall c=%0d got=%b exp=%b", c, alu_stall_o, (mcount == 4)); end
      push = ld_valid_i && (mcount < 4);
      pop  = !alu_valid_i && (mcount > 0);
      tick();
      if (push) begin mcount++; j++; end
      if (pop) mcount--;
      if (wr_en_o === 1'b1) writes++;
      if (c < 11) begin
        exp_rd   = (c < 6) ? 5'(10 + c) : 5'(20 + c - 6);
        exp_data = (c < 6) ? 32'hA000_0000 + 32'(c) : 32'hB000_0000 + 32'(c - 6);
        checks++; if (wr_en_o !== 1'b1 || rd_idx_o !== exp_rd || rd_data_o !== exp_data) begin
          failures++;
          $display("FAIL cont_write c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, wr_en_o, rd_idx_o, rd_data_o, exp_rd, exp_data);
        end
      end else begin
        checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL cont_drained_wr_en got=%b exp=0", wr_en_o); end
      end
    end
    idle_inputs();
    checks++; if (writes != 11) begin failures++; $display("FAIL cont_total_writes got=%0d exp=11", writes); end
  endtask

  task automatic test_x0();
    // ALU write to x0 together with a queued load to x0 and a load issue to 12.
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h0000_0055;
    ld_valid_i = 1'b1; ld_rd_i = 5'd0; ld_data_i = 32'h0000_0077;
    issue_load_i = 1'b1; issue_rd_i = 5'd12;
    tick();
    idle_inputs();
    checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL x0_alu_wr_en got=%b exp=0", wr_en_o); end
    checks++; if (rd_data_o !== 32'h0000_0055) begin failures++; $display("FAIL x0_alu_rd_data got=%h exp=00000055", rd_data_o); end
    tick();                                   // x0 load popped
    checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL x0_load_wr_en got=%b exp=0", wr_en_o); end
    checks++; if (rd_idx_o !== 5'd0 || rd_data_o !== 32'h0000_0077) begin failures++; $display("FAIL x0_load_pop got=%0d/%h exp=0/00000077", rd_idx_o, rd_data_o); end
    chk_rs1_i = 5'd12; chk_rs2_i = 5'd0;
    #1;
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL x0_pend_kept got=%b exp=1", hazard_o); end
    chk_rs1_i = 5'd0;
    #1;
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL x0_no_hazard got=%b exp=0", hazard_o); end
    tick();                                   // queue now empty: nothing more written
    checks++; if (wr_en_o !== 1'b0 || rd_data_o !== 32'h0000_0077) begin failures++; $display("FAIL x0_empty got=%b/%h exp=0/00000077", wr_en_o, rd_data_o); end
  endtask

  task automatic test_race();
    issue_load_i = 1'b1; issue_rd_i = 5'd3;
    tick();
    idle_inputs();
    ld_valid_i = 1'b1; ld_rd_i = 5'd3; ld_data_i = 32'h0000_0033;
    tick();                                   // load to x3 queued
    idle_inputs();
    issue_load_i = 1'b1; issue_rd_i = 5'd3;   // issue coincides with the pop
    tick();
    idle_inputs();
    chk_rs1_i = 5'd0; chk_rs2_i = 5'd3;
    #1;
    checks++; if (wr_en_o !== 1'b1 || rd_idx_o !== 5'd3 || rd_data_o !== 32'h0000_0033) begin failures++; $display("FAIL race_write got=%b/%0d/%h exp=1/3/00000033", wr_en_o, rd_idx_o, rd_data_o); end
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL race_set_wins got=%b exp=1", hazard_o); end
    chk_rs2_i = 5'd0;
  endtask

  task automatic test_reset_mid();
    issue_load_i = 1'b1; issue_rd_i = 5'd9;
    for (int k = 0; k < 3; k++) begin
      alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h0000_0100 + 32'(k);
      ld_valid_i = 1'b1; ld_rd_i = 5'd9; ld_data_i = 32'h0000_0090 + 32'(k);
      tick();
      issue_load_i = 1'b0;
    end
    idle_inputs();
    chk_rs1_i = 5'd9;
    #1;
    checks++; if (wr_en_o !== 1'b1 || hazard_o !== 1'b1) begin failures++; $display("FAIL rmid_before got=%b/%b exp=1/1", wr_en_o, hazard_o); end
    #1;
    rst_i = 1'b1;
    #1;
    checks++; if (wr_en_o !== 1'b0 || rd_idx_o !== 5'd0 || rd_data_o !== 32'd0) begin failures++; $display("FAIL rmid_async_out got=%b/%0d/%h exp=0/0/0", wr_en_o, rd_idx_o, rd_data_o); end
    checks++; if (ld_ready_o !== 1'b0 || hazard_o !== 1'b0) begin failures++; $display("FAIL rmid_async_ctl got=%b/%b exp=0/0", ld_ready_o, hazard_o); end
    #1;
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (wr_en_o !== 1'b0) begin failures++; $display("FAIL rmid_no_write k=%0d got=%b exp=0", k, wr_en_o); end
    end
    checks++; if (ld_ready_o !== 1'b1 || hazard_o !== 1'b0) begin failures++; $display("FAIL rmid_after got=%b/%b exp=1/0", ld_ready_o, hazard_o); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alu();
    test_load();
    test_contention();
    test_x0();
    test_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
